// File: rtl/shift_arbiter.sv
// Two requesters share one shifter and one result register. Define SHIFT_ARBITER_RR_EN for round-robin, otherwise requester 0 has fixed priority.
// Latency 1 cycle, 1 result/cycle while out_ready=1; a held (unconsumed) result blocks all new accepts.
module shift_arbiter #(
   parameter int DATA_W  = 4,
   parameter int SHIFT_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [DATA_W-1:0]  req0_data,
   input  logic [SHIFT_W-1:0] req0_shift,
   input  logic [1:0]         req0_mode,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [DATA_W-1:0]  req1_data,
   input  logic [SHIFT_W-1:0] req1_shift,
   input  logic [1:0]         req1_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_id
);

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   localparam logic [1:0] MODE_LSL = 2'b00;
   localparam logic [1:0] MODE_LSR = 2'b01;
   localparam logic [1:0] MODE_ROL = 2'b10;

   // Rotates shift a doubled copy of the operand so wrapped bits fall into the kept half.
   function automatic logic [DATA_W-1:0] f_shift(
      input logic [DATA_W-1:0]  d,
      input logic [SHIFT_W-1:0] s,
      input logic [1:0]         m
   );
      logic [2*DATA_W-1:0] w_dbl;
      logic [DATA_W-1:0]   w_res;
      w_dbl = {d, d};
      case (m)
         MODE_LSL: w_res = d << s;
         MODE_LSR: w_res = d >> s;
         MODE_ROL: begin
            w_dbl = w_dbl << s;
            w_res = w_dbl[2*DATA_W-1:DATA_W];
         end
         default: begin
            w_dbl = w_dbl >> s;
            w_res = w_dbl[DATA_W-1:0];
         end
      endcase
      return w_res;
   endfunction

   state_t              r_state;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_id;

   logic                w_slot;
   logic                w_prio1;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_accept;
   logic                w_sel_id;
   logic [DATA_W-1:0]   w_sel_data;
   logic [SHIFT_W-1:0]  w_sel_shift;
   logic [1:0]          w_sel_mode;
   logic [DATA_W-1:0]   w_result;

`ifdef SHIFT_ARBITER_RR_EN
   logic                r_prio1;
   assign w_prio1 = r_prio1;
`else
   assign w_prio1 = 1'b0;
`endif

   always_comb begin
      w_slot      = !rst && ((r_state == ST_EMPTY) || out_ready);
      w_gnt1      = req1_valid && (!req0_valid || w_prio1);
      w_gnt0      = req0_valid && !w_gnt1;
      req0_ready  = w_slot && w_gnt0;
      req1_ready  = w_slot && w_gnt1;
      w_accept    = req0_ready || req1_ready;
      w_sel_id    = w_gnt1;
      w_sel_data  = w_gnt1 ? req1_data  : req0_data;
      w_sel_shift = w_gnt1 ? req1_shift : req0_shift;
      w_sel_mode  = w_gnt1 ? req1_mode  : req0_mode;
      w_result    = f_shift(w_sel_data, w_sel_shift, w_sel_mode);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_out_data <= '0;
         r_out_id   <= 1'b0;
`ifdef SHIFT_ARBITER_RR_EN
         r_prio1    <= 1'b0;
`endif
      end else if (w_accept) begin
         r_state    <= ST_FULL;
         r_out_data <= w_result;
         r_out_id   <= w_sel_id;
`ifdef SHIFT_ARBITER_RR_EN
         // Next contention favours whoever was not just granted.
         r_prio1    <= ~w_sel_id;
`endif
      end else if (out_ready) begin
         r_state    <= ST_EMPTY;
      end
   end

   assign out_valid = (r_state == ST_FULL);
   assign out_data  = r_out_data;
   assign out_id    = r_out_id;

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 4, operand width; power of two, minimum 2.
REQ-002 SHALL have parameter: SHIFT_W, 2, shift-amount width; DATA_W == 2**SHIFT_W.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-006 SHALL have ports: req0_ready / req1_ready  output  1  requester n operation accepted this cycle.
REQ-007 SHALL have ports: req0_data / req1_data  input  DATA_W  operand.
REQ-008 SHALL have ports: req0_shift / req1_shift  input  SHIFT_W  shift amount.
REQ-009 SHALL have ports: req0_mode / req1_mode  input  2  00 logical left, 01 logical right, 10 rotate left, 11 rotate right.
REQ-010 SHALL have port: out_valid  output  1  result register holds a result.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port: out_data  output  DATA_W  shifted result.
REQ-013 SHALL have port: out_id  output  1  index of the requester that produced out_data.

Function
REQ-014 SHALL contain one shared shift unit and one result register; states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL take an accept slot when state is EMPTY, or when state is FULL and out_ready=1 in the same cycle.
REQ-016 SHALL assert at most one reqN_ready per cycle; readiness is combinational from the reqN_valid signals, state, out_ready, and the priority pointer.
REQ-017 SHALL assert reqN_ready only when reqN_valid=1, an accept slot exists, and requester N wins arbitration.
REQ-018 SHALL, on accept, load out_data with the shifted operand, load out_id=N, and set out_valid=1 on the next edge; latency is 1 cycle, and throughput is 1 per cycle while out_ready=1.
REQ-019 SHALL leave FULL for EMPTY only when out_ready=1 and no accept occurs in that cycle.
REQ-020 SHALL hold out_data and out_id stable while out_valid=1 and out_ready=0.
REQ-021 SHALL define shifts modulo DATA_W: logical shifts zero-fill; rotates wrap bits; shift=0 in any mode returns the operand unchanged.
REQ-022 SHALL ignore req data, shift, and mode inputs in cycles where that requester is not accepted.
REQ-023 SHALL keep out_valid=1 and reqN_ready=0 on every cycle while out_ready=0 in FULL, with no data loss.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, set out_valid=0, out_data=0, out_id=0, state EMPTY, and the priority pointer to favour requester 0.
REQ-025 SHALL drive req0_ready=0 and req1_ready=0 in any cycle where rst=1.
REQ-026 SHALL discard a held result when reset is asserted mid-operation; no accept occurs in the reset cycle.

Configuration
REQ-027 SHALL provide macro SHIFT_ARBITER_RR_EN.
REQ-028 SHALL, with SHIFT_ARBITER_RR_EN defined, arbitrate round-robin: on contention, grant the requester not granted last; the pointer updates only on accept.
REQ-029 SHALL, with SHIFT_ARBITER_RR_EN undefined, use fixed priority with requester 0 always winning contention; no pointer state is implemented.

Verification
REQ-030 SHALL cover single request: req0 data=1011, shift=1, mode=10, out_ready=1 -> next cycle out_valid=1, out_data=0111, out_id=0.
REQ-031 SHALL cover all modes: data=1001, shift=2, each mode -> 0100, 0010, 0110, 0110; shift=0 in each mode -> 1001.
REQ-032 SHALL cover contention: both valid for 4 cycles, out_ready=1 -> with RR_EN, out_id sequence 0,1,0,1; without it, 0,0,0,0.
REQ-033 SHALL cover backpressure: FULL with out_ready=0 for 3 cycles while req1 is valid -> out_data held, req1_ready=0; out_ready=1 -> req1 accepted the same cycle.
REQ-034 SHALL cover reset mid-operation: FULL with out_ready=0, rst=1 for one cycle -> out_valid=0, out_data=0, out_id=0, both readies 0; the next contention grants requester 0.
